// File: rtl/vga_timing_gen_if.sv
// Video timing bundle shared by the timing generator and its consumers.
// frame_count is only live when the design is built with VGA_TIMING_FRAME_CNT_EN.
interface vga_timing_gen_if;
  logic        pix_en;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    input  pix_en,
    output hcount, vcount, hsync, vsync, blank, frame_start, frame_count
  );

  modport slave (
    output pix_en,
    input  hcount, vcount, hsync, vsync, blank, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 defaults) with pixel-rate enable.
// Optional completed-frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcount_reg, hcount_next;
  logic [10:0] vcount_reg, vcount_next;
  logic        hsync_reg, vsync_reg, blank_reg, frame_start_reg;
  logic        h_wrap, frame_wrap;

  // Decode syncs/blank from the next counter values so the registered
  // flags line up with the counters they describe.
  always_comb begin
    h_wrap      = (hcount_reg == H_LAST);
    frame_wrap  = h_wrap && (vcount_reg == V_LAST);
    hcount_next = h_wrap ? 11'd0 : hcount_reg + 11'd1;
    vcount_next = vcount_reg;
    if (h_wrap) begin
      vcount_next = (vcount_reg == V_LAST) ? 11'd0 : vcount_reg + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_reg      <= 11'd0;
      vcount_reg      <= 11'd0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      blank_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      if (vif.pix_en) begin
        hcount_reg      <= hcount_next;
        vcount_reg      <= vcount_next;
        blank_reg       <= (hcount_next >= H_VIS) || (vcount_next >= V_VIS);
        hsync_reg       <= !((hcount_next >= HS_FIRST) && (hcount_next <= HS_LAST));
        vsync_reg       <= !((vcount_next >= VS_FIRST) && (vcount_next <= VS_LAST));
        frame_start_reg <= frame_wrap;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  // Bumps on the same edge that raises frame_start, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_reg <= 16'd0;
    end else if (vif.pix_en && frame_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign vif.frame_count = frame_cnt_reg;
`else
  assign vif.frame_count = 16'd0;
`endif

  assign vif.hcount      = hcount_reg;
  assign vif.vcount      = vcount_reg;
  assign vif.hsync       = hsync_reg;
  assign vif.vsync       = vsync_reg;
  assign vif.blank       = blank_reg;
  assign vif.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, shrunken raster
// instance (16x10 total) for whole-frame, vsync and frame_start behaviour.
module tb_vga_timing_gen;

  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if vif_a ();
  vga_timing_gen_if vif_s ();

  vga_timing_gen dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_s (
    .clk   (clk),
    .reset (reset),
    .vif   (vif_s)
  );

  // Expected {hcount, vcount, blank, hsync, vsync, frame_start} at position (h,v).
  function automatic logic [25:0] model_out(input int h, input int v,
      input int ha, input int hf, input int hs,
      input int va, input int vf, input int vs, input bit fs);
    logic bl, hsy, vsy;
    bl  = (h >= ha) || (v >= va);
    hsy = !((h >= ha + hf) && (h <= ha + hf + hs - 1));
    vsy = !((v >= va + vf) && (v <= va + vf + vs - 1));
    return {11'(h), 11'(v), bl, hsy, vsy, fs};
  endfunction

  function automatic logic [25:0] big_out(input int h, input int v, input bit fs);
    return model_out(h, v, 640, 16, 96, 480, 10, 2, fs);
  endfunction

  function automatic logic [25:0] small_out(input int h, input int v, input bit fs);
    return model_out(h, v, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, fs);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    vif_a.pix_en = 1'b0;
    vif_s.pix_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] act;
    reset = 1'b1;
    vif_a.pix_en = 1'b1;
    vif_s.pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    act = {vif_a.hcount, vif_a.vcount, vif_a.blank, vif_a.hsync, vif_a.vsync, vif_a.frame_start};
    total++;
    if (act !== {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL reset_state_big: got %h want %h", act, {11'd0, 11'd0, 4'b0110});
    else passed++;
    total++;
    if (vif_a.frame_count !== 16'd0)
      $display("FAIL reset_frame_count: got %0d want 0", vif_a.frame_count);
    else passed++;
    act = {vif_s.hcount, vif_s.vcount, vif_s.blank, vif_s.hsync, vif_s.vsync, vif_s.frame_start};
    total++;
    if (act !== {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL reset_state_small: got %h want %h", act, {11'd0, 11'd0, 4'b0110});
    else passed++;
  endtask

  task automatic test_line();
    logic [25:0] act, exp;
    int low_cnt;
    int eh, ev;
    do_reset();
    low_cnt = 0;
    vif_a.pix_en = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      @(posedge clk);
      #1;
      eh = i % 800;
      ev = i / 800;
      exp = big_out(eh, ev, 1'b0);
      act = {vif_a.hcount, vif_a.vcount, vif_a.blank, vif_a.hsync, vif_a.vsync, vif_a.frame_start};
      total++;
      if (act !== exp)
        $display("FAIL line_step_%0d: got h=%0d v=%0d b/hs/vs/fs=%b want h=%0d v=%0d b/hs/vs/fs=%b",
                 i, act[25:15], act[14:4], act[3:0], eh, ev, exp[3:0]);
      else passed++;
      if (vif_a.hsync === 1'b0) low_cnt++;
    end
    total++;
    if (low_cnt !== 96)
      $display("FAIL hsync_low_width: got %0d want 96", low_cnt);
    else passed++;
  endtask

  task automatic test_pix_en_toggle();
    logic [21:0] act;
    int eh, ev;
    bit pen;
    do_reset();
    eh = 0;
    ev = 0;
    for (int i = 0; i < 1600; i++) begin
      pen = (i % 2 == 0);
      vif_a.pix_en = pen;
      @(posedge clk);
      #1;
      if (pen) begin
        eh++;
        if (eh == 800) begin
          eh = 0;
          ev++;
        end
      end
      act = {vif_a.hcount, vif_a.vcount};
      total++;
      if (act !== {11'(eh), 11'(ev)} || vif_a.frame_start !== 1'b0)
        $display("FAIL toggle_step_%0d: got h=%0d v=%0d fs=%b want h=%0d v=%0d fs=0",
                 i, vif_a.hcount, vif_a.vcount, vif_a.frame_start, eh, ev);
      else passed++;
    end
    total++;
    if (vif_a.hcount !== 11'd0 || vif_a.vcount !== 11'd1)
      $display("FAIL toggle_line_1600: got h=%0d v=%0d want h=0 v=1", vif_a.hcount, vif_a.vcount);
    else passed++;
  endtask

  task automatic test_frame();
    logic [25:0] act, exp;
    int eh, ev, vs_low, fs_cnt;
    bit efs, pen;
    do_reset();
    eh = 0;
    ev = 0;
    vs_low = 0;
    fs_cnt = 0;
    vif_s.pix_en = 1'b1;
    for (int i = 1; i <= S_HT * S_VT; i++) begin
      @(posedge clk);
      #1;
      efs = 1'b0;
      eh++;
      if (eh == S_HT) begin
        eh = 0;
        ev++;
        if (ev == S_VT) begin
          ev = 0;
          efs = 1'b1;
        end
      end
      exp = small_out(eh, ev, efs);
      act = {vif_s.hcount, vif_s.vcount, vif_s.blank, vif_s.hsync, vif_s.vsync, vif_s.frame_start};
      total++;
      if (act !== exp)
        $display("FAIL frame_step_%0d: got h=%0d v=%0d b/hs/vs/fs=%b want h=%0d v=%0d b/hs/vs/fs=%b",
                 i, act[25:15], act[14:4], act[3:0], eh, ev, exp[3:0]);
      else passed++;
      if (vif_s.vsync === 1'b0) vs_low++;
      if (vif_s.frame_start === 1'b1) fs_cnt++;
    end
    total++;
    if (vs_low !== S_VS * S_HT)
      $display("FAIL vsync_low_width: got %0d want %0d", vs_low, S_VS * S_HT);
    else passed++;
    total++;
    if (fs_cnt !== 1)
      $display("FAIL frame_start_pulses: got %0d want 1", fs_cnt);
    else passed++;
    total++;
`ifdef VGA_TIMING_FRAME_CNT_EN
    if (vif_s.frame_count !== 16'd1)
      $display("FAIL frame_count_one: got %0d want 1", vif_s.frame_count);
    else passed++;
`else
    if (vif_s.frame_count !== 16'd0)
      $display("FAIL frame_count_off: got %0d want 0", vif_s.frame_count);
    else passed++;
`endif

    // Second frame at half rate: the start pulse must still be one clk wide.
    fs_cnt = 0;
    for (int i = 0; i < 2 * S_HT * S_VT; i++) begin
      pen = (i % 2 == 1);
      vif_s.pix_en = pen;
      @(posedge clk);
      #1;
      if (vif_s.frame_start === 1'b1) fs_cnt++;
    end
    total++;
    if (fs_cnt !== 1 || vif_s.frame_start !== 1'b1 || vif_s.hcount !== 11'd0 || vif_s.vcount !== 11'd0)
      $display("FAIL toggle_frame_start: got pulses=%0d fs=%b h=%0d v=%0d want pulses=1 fs=1 h=0 v=0",
               fs_cnt, vif_s.frame_start, vif_s.hcount, vif_s.vcount);
    else passed++;
    total++;
`ifdef VGA_TIMING_FRAME_CNT_EN
    if (vif_s.frame_count !== 16'd2)
      $display("FAIL frame_count_two: got %0d want 2", vif_s.frame_count);
    else passed++;
`else
    if (vif_s.frame_count !== 16'd0)
      $display("FAIL frame_count_off2: got %0d want 0", vif_s.frame_count);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_sync();
    logic [25:0] act;
    do_reset();
    vif_s.pix_en = 1'b1;
    for (int i = 0; i < 7 * S_HT + 11; i++) @(posedge clk);
    #1;
    act = {vif_s.hcount, vif_s.vcount, vif_s.blank, vif_s.hsync, vif_s.vsync, vif_s.frame_start};
    total++;
    if (act !== small_out(11, 7, 1'b0))
      $display("FAIL mid_sync_position: got %h want %h", act, small_out(11, 7, 1'b0));
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    act = {vif_s.hcount, vif_s.vcount, vif_s.blank, vif_s.hsync, vif_s.vsync, vif_s.frame_start};
    total++;
    if (act !== {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL async_reset_small: got %h want %h", act, {11'd0, 11'd0, 4'b0110});
    else passed++;

    do_reset();
    vif_a.pix_en = 1'b1;
    for (int i = 0; i < 700; i++) @(posedge clk);
    #1;
    act = {vif_a.hcount, vif_a.vcount, vif_a.blank, vif_a.hsync, vif_a.vsync, vif_a.frame_start};
    total++;
    if (act !== big_out(700, 0, 1'b0))
      $display("FAIL mid_line_position: got %h want %h", act, big_out(700, 0, 1'b0));
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    act = {vif_a.hcount, vif_a.vcount, vif_a.blank, vif_a.hsync, vif_a.vsync, vif_a.frame_start};
    total++;
    if (act !== {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL async_reset_big: got %h want %h", act, {11'd0, 11'd0, 4'b0110});
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    act = {vif_a.hcount, vif_a.vcount, vif_a.blank, vif_a.hsync, vif_a.vsync, vif_a.frame_start};
    total++;
    if (act !== big_out(1, 0, 1'b0))
      $display("FAIL first_edge_after_reset: got %h want %h", act, big_out(1, 0, 1'b0));
    else passed++;
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_count_wrap();
    do_reset();
    dut_s.frame_cnt_reg = 16'hFFFF;
    vif_s.pix_en = 1'b1;
    for (int i = 0; i < S_HT * S_VT; i++) @(posedge clk);
    #1;
    total++;
    if (vif_s.frame_count !== 16'd0 || vif_s.frame_start !== 1'b1)
      $display("FAIL frame_count_wrap: got cnt=%0d fs=%b want cnt=0 fs=1",
               vif_s.frame_count, vif_s.frame_start);
    else passed++;
  endtask
`endif

  initial begin
    vif_a.pix_en = 1'b0;
    vif_s.pix_en = 1'b0;
    test_reset();
    test_line();
    test_pix_en_toggle();
    test_frame();
    test_reset_mid_sync();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_count_wrap();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", total);
    $fatal(1, "timeout");
  end

endmodule
